pwm_duty_sched: RTL and testbench

Duty-cycle scheduler that sits in front of the 11-bit PWM generator and owns its duty input. Two requesters supply target duties through valid/ready handshakes: A is the balance/steering control loop, B is the override path (fault, brake, test). B has fixed priority over A. The block slew-limits the applied duty, updating it only on the PWM period-start pulse so a PWM period never sees a mid-period change. It also sequences enable (soft start) and disable (soft stop).

---
 rtl/pwm_duty_sched.sv | 120 ++++++++++++
 tb/tb_pwm_duty_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - slew-limited duty scheduler with A/B target arbitration and soft start/stop
module pwm_duty_sched #(
  parameter int DW       = 11,
  parameter int STEP     = 16,
  parameter int MAX_DUTY = 2047
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          synch,
  input  logic          a_vld,
  input  logic [DW-1:0] a_duty,
  output logic          a_rdy,
  input  logic          b_vld,
  input  logic [DW-1:0] b_duty,
  output logic          b_rdy,
  output logic [DW-1:0] duty,
  output logic [1:0]    state,
  output logic          at_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [DW:0] STEP_W = (DW+1)'(STEP);
  localparam logic [DW:0] MAX_W  = (DW+1)'(MAX_DUTY);

  state_t        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic          at_target_q, at_target_d;
  logic [DW-1:0] eff_q, eff_d;
  logic [DW:0]   diff;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v);
    return ({1'b0, v} > MAX_W) ? MAX_W[DW-1:0] : v;
  endfunction

  assign b_rdy = (state_q == RAMP) || (state_q == RUN);
  assign a_rdy = b_rdy && !b_vld;

  always_comb begin
    tgt_d = tgt_q;
    if (b_vld && b_rdy) begin
      tgt_d = clamp(b_duty);
    end else if (a_vld && a_rdy) begin
      tgt_d = clamp(a_duty);
    end
  end

  // Slew works from the registered target, so a target accepted on a synch edge waits one period.
  assign eff_q = b_rdy ? tgt_q : '0;

  always_comb begin
    duty_d = duty_q;
    diff   = '0;
    if (state_q == IDLE) begin
      duty_d = '0;
    end else if (synch) begin
      if (duty_q < eff_q) begin
        diff   = {1'b0, eff_q} - {1'b0, duty_q};
        duty_d = (diff > STEP_W) ? duty_q + STEP_W[DW-1:0] : eff_q;
      end else if (duty_q > eff_q) begin
        diff   = {1'b0, duty_q} - {1'b0, eff_q};
        duty_d = (diff > STEP_W) ? duty_q - STEP_W[DW-1:0] : eff_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = RAMP;
      RAMP: begin
        if (!en) begin
          state_d = STOP;
        end else if (synch && (duty_d == tgt_q)) begin
          state_d = RUN;
        end
      end
      RUN:  if (!en) state_d = STOP;
      STOP: begin
        if (en) begin
          state_d = RAMP;
        end else if (duty_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eff_d       = ((state_d == RAMP) || (state_d == RUN)) ? tgt_d : '0;
    at_target_d = (duty_d == eff_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      tgt_q       <= '0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      at_target_q <= at_target_d;
    end
  end

  assign duty      = duty_q;
  assign state     = state_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb/tb_pwm_duty_sched.sv - directed self-checking bench for pwm_duty_sched
module tb_pwm_duty_sched;
  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          rst_n, en, synch, a_vld, b_vld;
  logic [DW-1:0] a_duty, b_duty, duty;
  logic          a_rdy, b_rdy, at_target;
  logic [1:0]    state;
  int            compared = 0;
  int            mismatched = 0;
  int            exp_d;

  always #5 clk = ~clk;

  pwm_duty_sched #(.DW(DW), .STEP(16), .MAX_DUTY(1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .synch(synch),
    .a_vld(a_vld), .a_duty(a_duty), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_duty(b_duty), .b_rdy(b_rdy),
    .duty(duty), .state(state), .at_target(at_target)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse;
    synch = 1'b1;
    tick();
    synch = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_duty(input string tag, input int exp);
    check(tag, int'(duty), exp);
  endtask

  task automatic chk_state(input string tag, input int exp);
    check(tag, int'(state), exp);
  endtask

  task automatic chk_at(input string tag, input int exp);
    check(tag, int'(at_target), exp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; synch = 1'b0;
    a_vld = 1'b1; a_duty = 11'd100; b_vld = 1'b0; b_duty = '0;
    tick();
    chk_duty("rst_duty", 0);
    chk_state("rst_state", 0);
    chk_at("rst_at", 1);
    check("rst_a_rdy", int'(a_rdy), 0);
    check("rst_b_rdy", int'(b_rdy), 0);

    // soft start to 100
    rst_n = 1'b1; en = 1'b1;
    tick();
    chk_state("start_ramp", 1);
    chk_at("start_at_tgt0", 1);
    check("start_a_rdy", int'(a_rdy), 1);
    tick();
    a_vld = 1'b0;
    chk_at("accept100_at", 0);
    chk_duty("accept100_duty", 0);
    for (int k = 1; k <= 7; k++) begin
      pulse();
      chk_duty("ramp_up", (16 * k > 100) ? 100 : 16 * k);
      if (k < 7) chk_state("ramp_state", 1);
    end
    chk_state("run_reached", 2);
    chk_at("run_at", 1);

    // simultaneous A and B: B wins
    a_vld = 1'b1; a_duty = 11'd500; b_vld = 1'b1; b_duty = 11'd50;
    #1;
    check("arb_b_rdy", int'(b_rdy), 1);
    check("arb_a_rdy", int'(a_rdy), 0);
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    chk_at("arb_at", 0);
    exp_d = 100;
    for (int k = 0; k < 4; k++) begin
      pulse();
      exp_d = (exp_d - 16 < 50) ? 50 : exp_d - 16;
      chk_duty("slew_down_50", exp_d);
    end
    chk_at("at50", 1);

    // back to 100, then accept 300 on a synch edge
    a_vld = 1'b1; a_duty = 11'd100;
    tick();
    a_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse();
      exp_d = (exp_d + 16 > 100) ? 100 : exp_d + 16;
      chk_duty("slew_up_100", exp_d);
    end
    a_vld = 1'b1; a_duty = 11'd300; synch = 1'b1;
    tick();
    a_vld = 1'b0; synch = 1'b0;
    chk_duty("same_edge_hold", 100);
    chk_at("same_edge_at", 0);
    pulse();
    chk_duty("same_edge_next", 116);

    // clamp to MAX_DUTY=1000
    a_vld = 1'b1; a_duty = 11'd2047;
    tick();
    a_vld = 1'b0;
    exp_d = 116;
    for (int k = 0; k < 56; k++) begin
      pulse();
      exp_d = (exp_d + 16 > 1000) ? 1000 : exp_d + 16;
      chk_duty("clamp_slew", exp_d);
    end
    pulse();
    chk_duty("clamp_hold", 1000);
    chk_at("clamp_at", 1);
    chk_state("clamp_state", 2);

    a_vld = 1'b1; a_duty = 11'd100;
    tick();
    a_vld = 1'b0;
    for (int k = 0; k < 57; k++) begin
      pulse();
      exp_d = (exp_d - 16 < 100) ? 100 : exp_d - 16;
    end
    chk_duty("back_to_100", 100);

    // soft stop to idle
    en = 1'b0;
    tick();
    chk_state("stop_state", 3);
    check("stop_a_rdy", int'(a_rdy), 0);
    check("stop_b_rdy", int'(b_rdy), 0);
    chk_duty("stop_duty_hold", 100);
    exp_d = 100;
    for (int k = 0; k < 7; k++) begin
      pulse();
      exp_d = (exp_d < 16) ? 0 : exp_d - 16;
      chk_duty("stop_slew", exp_d);
    end
    chk_state("stop_idle", 0);
    chk_at("idle_at", 1);

    // restart, stop, and re-enable mid-stop at 36
    en = 1'b1;
    tick();
    chk_state("restart_ramp", 1);
    chk_at("restart_tgt_kept", 0);
    for (int k = 0; k < 7; k++) pulse();
    chk_duty("restart_100", 100);
    chk_state("restart_run", 2);
    en = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) pulse();
    chk_duty("stop_at_36", 36);
    chk_state("stop_at_36_state", 3);
    en = 1'b1;
    tick();
    chk_state("reenable_ramp", 1);
    exp_d = 36;
    for (int k = 0; k < 4; k++) begin
      pulse();
      exp_d = (exp_d + 16 > 100) ? 100 : exp_d + 16;
      chk_duty("reenable_climb", exp_d);
    end
    chk_state("reenable_run", 2);
    chk_at("reenable_at", 1);

    // reset mid-RAMP at 48 with A pending
    en = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) pulse();
    chk_state("pre_rst_idle", 0);
    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) pulse();
    chk_duty("pre_rst_48", 48);
    chk_state("pre_rst_ramp", 1);
    a_vld = 1'b1; a_duty = 11'd700; rst_n = 1'b0; en = 1'b0;
    tick();
    chk_duty("midrst_duty", 0);
    chk_state("midrst_state", 0);
    check("midrst_a_rdy", int'(a_rdy), 0);
    chk_at("midrst_at", 1);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_a_rdy", int'(a_rdy), 0);
    chk_state("post_rst_idle", 0);
    en = 1'b1;
    tick();
    chk_state("post_rst_ramp", 1);
    chk_at("post_rst_tgt_dropped", 1);
    tick();
    a_vld = 1'b0;
    chk_at("post_rst_accept", 0);
    pulse();
    chk_duty("post_rst_first_step", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
